// File: rtl/alu_slice_seq.sv
// Multi-cycle 74181-style ALU: one SLICE_W-bit slice per clock with a ripple carry register,
// valid/ready handshakes, accumulator operand path and zero/carry/overflow/equality flags.
module alu_slice_seq #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             mode,
  input  logic             cin,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             aeqb
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   result_r;
  logic [WIDTH-1:0]   result_s;
  logic [3:0]         sel_r;
  logic               mode_r;
  logic               carry_r;
  logic [IDX_W-1:0]   idx_r;
  logic               cout_r;
  logic               ovf_r;
  logic               zero_r;
  logic               aeqb_r;
  logic               accept_s;
  logic               last_s;
  logic [SLICE_W-1:0] slice_a_s;
  logic [SLICE_W-1:0] slice_b_s;
  logic [SLICE_W-1:0] slice_f_s;
  logic               slice_co_s;
  logic               slice_cm_s;

  // Returns {carry out of slice MSB, carry into slice MSB, F}; carries are 0 in logic mode.
  function automatic logic [SLICE_W+1:0] slice_calc(
    input logic [SLICE_W-1:0] a_i,
    input logic [SLICE_W-1:0] b_i,
    input logic [3:0]         s_i,
    input logic               m_i,
    input logic               c_i
  );
    logic [SLICE_W-1:0] f_v;
    logic               c_v;
    logic               c_prev_v;
    logic               x_v;
    logic               y_v;
    c_v      = m_i ? 1'b0 : c_i;
    c_prev_v = 1'b0;
    f_v      = {SLICE_W{1'b0}};
    for (int i = 0; i < SLICE_W; i++) begin
      x_v = a_i[i] | (s_i[0] & b_i[i]) | (s_i[1] & ~b_i[i]);
      y_v = a_i[i] & ((s_i[3] & b_i[i]) | (s_i[2] & ~b_i[i]));
      if (m_i) begin
        f_v[i]   = ~(x_v ^ y_v);
        c_prev_v = 1'b0;
        c_v      = 1'b0;
      end else begin
        f_v[i]   = x_v ^ y_v ^ c_v;
        c_prev_v = c_v;
        c_v      = (x_v & y_v) | (x_v & c_v) | (y_v & c_v);
      end
    end
    return {c_v, c_prev_v, f_v};
  endfunction

  assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
  assign out_valid = (state_r == ST_DONE);
  assign result    = result_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;
  assign aeqb      = aeqb_r;

  // Next-state decode and request acceptance.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready && in_valid) begin
          accept_s = 1'b1;
          state_s  = ST_RUN;
        end else if (out_ready) begin
          state_s  = ST_IDLE;
        end else begin
          state_s  = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Current slice evaluation and the result word with that slice merged in.
  always_comb begin
    last_s    = (idx_r == IDX_W'(NSLICE - 1));
    slice_a_s = a_r[idx_r*SLICE_W +: SLICE_W];
    slice_b_s = b_r[idx_r*SLICE_W +: SLICE_W];
    {slice_co_s, slice_cm_s, slice_f_s} = slice_calc(slice_a_s, slice_b_s, sel_r, mode_r, carry_r);
    result_s  = result_r;
    result_s[idx_r*SLICE_W +: SLICE_W] = slice_f_s;
  end

  // State, operand latches, slice progress and flags; the result register doubles as accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      sel_r    <= 4'd0;
      mode_r   <= 1'b0;
      carry_r  <= 1'b0;
      idx_r    <= {IDX_W{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
      aeqb_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        a_r     <= acc_sel ? result_r : a;
        b_r     <= b;
        sel_r   <= sel;
        mode_r  <= mode;
        carry_r <= mode ? 1'b0 : cin;
        idx_r   <= {IDX_W{1'b0}};
      end else if (state_r == ST_RUN) begin
        result_r <= result_s;
        carry_r  <= slice_co_s;
        if (last_s) begin
          idx_r  <= {IDX_W{1'b0}};
          cout_r <= mode_r ? 1'b0 : slice_co_s;
          ovf_r  <= mode_r ? 1'b0 : (slice_cm_s ^ slice_co_s);
          zero_r <= (result_s == {WIDTH{1'b0}});
          aeqb_r <= (a_r == b_r);
        end else begin
          idx_r  <= idx_r + IDX_W'(1);
        end
      end
    end
  end

endmodule
